apb_master_nslave: RTL and testbench
====================================

Name: apb_master_nslave

Overview:
- Parametrised APB master bridge; successor to the fixed two-slave, 9-bit-address, 8-bit-data bridge.
- Accepts single-beat read/write requests on a valid/ready request port and runs them as APB SETUP/ACCESS transfers.
- Decodes NUM_SLV slave selects from the address MSBs, muxes PRDATA/PREADY/PSLVERR back, and returns a one-cycle response with error and wait-state-timeout status.
- Sits between the test/host request logic and the APB slave array.

Parameters:
- ADDR_W, 9: PADDR width; top SEL_W bits select the slave.
- DATA_W, 8: PWDATA/PRDATA width.
- NUM_SLV, 2: slave count, power of two, 2..16. SEL_W = log2(NUM_SLV).
- TIMEOUT, 16: max ACCESS cycles waiting for PREADY; 0 disables timeout.

Ports:
- PCLK  in  1  clock; all logic on rising edge.
- PRESETn  in  1  reset, synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  target address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  PSLVERR seen or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- PSEL  out  NUM_SLV  one-hot slave select.
- PENABLE  out  1  APB access phase.
- PADDR  out  ADDR_W  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_W  APB write data.
- PRDATA  in  NUM_SLV*DATA_W  slave k read data at [k*DATA_W +: DATA_W].
- PREADY  in  NUM_SLV  per-slave ready.
- PSLVERR  in  NUM_SLV  per-slave error.

Behaviour:
- Reset (PRESETn low at a PCLK edge):
  - state = IDLE.
  - PSEL = 0, PENABLE = 0, PADDR = 0, PWRITE = 0, PWDATA = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, rsp_timeout = 0.
  - Wait counter = 0.
  - Reset mid-transfer abandons it with no response.
- All APB outputs are registered and held stable from SETUP through the end of ACCESS.
- States: IDLE, SETUP, ACCESS (encoding in package).
- IDLE:
  - req_ready = 1.
  - On accept: latch addr/wdata/write into PADDR/PWDATA/PWRITE; set PSEL[req_addr[ADDR_W-1 -: SEL_W]] = 1; go SETUP.
- SETUP:
  - Exactly one cycle, PENABLE = 0, req_ready = 0.
  - Go ACCESS with PENABLE = 1 and wait counter = 0.
- ACCESS completion: PREADY[sel] = 1.
  - Next edge, rsp_valid = 1 for one cycle.
  - rsp_err = PSLVERR[sel]; rsp_timeout = 0.
  - rsp_rdata = PRDATA[sel] for reads with no error, else 0.
- ACCESS wait: PREADY[sel] = 0, counter increments.
  - If TIMEOUT != 0 and counter reaches TIMEOUT-1 without PREADY: abort.
  - Abort response: rsp_valid = 1, rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0.
- req_ready in ACCESS = PREADY[sel] (combinational path; documented).
  - On completion with req_valid = 1: new request is latched and the FSM goes directly to SETUP (back-to-back, no IDLE cycle).
  - Otherwise PSEL = 0, PENABLE = 0, go IDLE.
- Timeout abort always returns to IDLE; no request is accepted in the abort cycle.
- PREADY and PSLVERR of non-selected slaves are ignored; PSLVERR is sampled only at completion.
- Latency: accept at edge N → SETUP at N+1 → ACCESS at N+2. Zero-wait response rsp_valid at N+3.
- No response back-pressure: the consumer must take rsp_valid in the pulse cycle.
- PADDR/PWDATA/PWRITE hold their last values in IDLE; they are not cleared.

Decomposition:
- Package apb_nslave_pkg holds:
  - state typedef/localparams IDLE/SETUP/ACCESS;
  - clog2-based SEL_W function;
  - response-code constants.
- One sub-module, apb_slave_mux: combinational one-hot PSEL decode from address MSBs, plus PRDATA/PREADY/PSLVERR select from the registered slave index. Parametrised by NUM_SLV, DATA_W.
- Wait timer stays inline.

Test Plan:
- Reset and zero-wait write:
  - Hold PRESETn low 3 cycles → all outputs 0.
  - Write addr 0x0A5, data 0x3C, slave 0 PREADY = 1 → PSEL = 01 for 2 cycles, PENABLE only in 2nd, PWDATA = 0x3C.
  - rsp_valid at accept+3, rsp_err = 0.
- Read with wait states:
  - Read addr 0x1F0 (slave 1), PREADY low 3 ACCESS cycles, PRDATA1 = 0x5A → PSEL = 10.
  - ACCESS lasts 4 cycles, rsp_rdata = 0x5A, rsp_err = 0.
- Back-to-back:
  - req_valid held high with write 0x010 then read 0x110, both zero-wait → second SETUP directly follows first ACCESS, no IDLE cycle.
  - Two rsp_valid pulses 2 cycles apart.
- Slave error:
  - Read slave 1 with PSLVERR1 = 1 at PREADY, PRDATA1 = 0xFF → rsp_err = 1, rsp_rdata = 0.
  - Slave 0 PSLVERR toggling during the transfer has no effect.
- Timeout:
  - TIMEOUT = 16, PREADY held 0 → abort after 16 ACCESS cycles: rsp_valid = 1, rsp_err = 1, rsp_timeout = 1, PSEL = 0 next cycle.
  - With TIMEOUT = 0, 100 waits → no abort.
- Reset mid-ACCESS and NUM_SLV = 4:
  - Assert PRESETn low during wait → next edge all outputs 0, no rsp_valid.
  - Rebuild NUM_SLV = 4, addr 0x180 → PSEL = 1000.

Source files
------------

// File: rtl/apb_nslave_pkg.sv
// Shared definitions for the parametrised APB master bridge: FSM encoding,
// slave-select width helper and response status codes.
package apb_nslave_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  // Bits needed to index NUM_SLV slaves (at least one).
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Response codes: bit 0 drives rsp_err, bit 1 drives rsp_timeout.
  localparam logic [1:0] RSP_OKAY    = 2'b00;
  localparam logic [1:0] RSP_SLVERR  = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT = 2'b11;

endpackage

// File: rtl/apb_slave_mux.sv
// Slave-side fan-out/fan-in: one-hot select decode for a new request and
// PRDATA/PREADY/PSLVERR selection for the transfer in flight.
module apb_slave_mux
  import apb_nslave_pkg::*;
#(
  parameter int NUM_SLV = 2,
  parameter int DATA_W  = 8,
  parameter int SEL_W   = sel_width(NUM_SLV)
) (
  input  logic [SEL_W-1:0]          dec_idx,
  input  logic [SEL_W-1:0]          sel_idx,
  output logic [NUM_SLV-1:0]        psel_dec,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR,
  output logic [DATA_W-1:0]         prdata_sel,
  output logic                      pready_sel,
  output logic                      pslverr_sel
);

  always_comb begin
    psel_dec          = '0;
    psel_dec[dec_idx] = 1'b1;
  end

  always_comb begin
    prdata_sel = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (sel_idx == SEL_W'(k)) prdata_sel = PRDATA[k*DATA_W +: DATA_W];
    end
  end

  assign pready_sel  = PREADY[sel_idx];
  assign pslverr_sel = PSLVERR[sel_idx];

endmodule

// File: rtl/apb_master_nslave.sv
// APB master bridge: single-beat valid/ready requests become SETUP/ACCESS
// transfers to one of NUM_SLV slaves, with a one-cycle status response.
module apb_master_nslave
  import apb_nslave_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int NUM_SLV = 2,
  parameter int TIMEOUT = 16
) (
  input  logic                      PCLK,
  input  logic                      PRESETn,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [NUM_SLV-1:0]        PSEL,
  output logic                      PENABLE,
  output logic [ADDR_W-1:0]         PADDR,
  output logic                      PWRITE,
  output logic [DATA_W-1:0]         PWDATA,
  input  logic [NUM_SLV*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]        PREADY,
  input  logic [NUM_SLV-1:0]        PSLVERR
);

  localparam int SEL_W = sel_width(NUM_SLV);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_t          state, state_nxt;
  logic [SEL_W-1:0]    sel_idx;
  logic [SEL_W-1:0]    dec_idx;
  logic [NUM_SLV-1:0]  psel_dec;
  logic [DATA_W-1:0]   prdata_sel;
  logic                pready_sel;
  logic                pslverr_sel;
  logic [CNT_W-1:0]    wait_cnt;
  logic                accept;
  logic                done;
  logic                abort;
  logic [1:0]          rsp_code;

  assign dec_idx = req_addr[ADDR_W-1 -: SEL_W];

  apb_slave_mux #(
    .NUM_SLV (NUM_SLV),
    .DATA_W  (DATA_W),
    .SEL_W   (SEL_W)
  ) u_mux (
    .dec_idx     (dec_idx),
    .sel_idx     (sel_idx),
    .psel_dec    (psel_dec),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR),
    .prdata_sel  (prdata_sel),
    .pready_sel  (pready_sel),
    .pslverr_sel (pslverr_sel)
  );

  always_ff @(posedge PCLK) begin
    if (!PRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS: begin
        if (done)       state_nxt = accept ? SETUP : IDLE;
        else if (abort) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // req_ready in ACCESS follows the selected slave's PREADY combinationally,
  // which is what allows a back-to-back accept on the completion edge.
  always_comb begin
    done      = (state == ACCESS) && pready_sel;
    abort     = (state == ACCESS) && !pready_sel && (TIMEOUT != 0) &&
                (wait_cnt == CNT_LAST);
    req_ready = (state == IDLE) || done;
    accept    = req_valid && req_ready;
    rsp_code  = RSP_TIMEOUT;
    if (done) rsp_code = pslverr_sel ? RSP_SLVERR : RSP_OKAY;
  end

  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      PSEL        <= '0;
      PENABLE     <= 1'b0;
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      sel_idx     <= '0;
      wait_cnt    <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (accept) begin
        PADDR   <= req_addr;
        PWDATA  <= req_wdata;
        PWRITE  <= req_write;
        sel_idx <= dec_idx;
        PSEL    <= psel_dec;
        PENABLE <= 1'b0;
      end else if (done || abort) begin
        PSEL    <= '0;
        PENABLE <= 1'b0;
      end else if (state == SETUP) begin
        PENABLE <= 1'b1;
      end

      if (state == SETUP)                    wait_cnt <= '0;
      else if (state == ACCESS && !pready_sel) wait_cnt <= wait_cnt + CNT_W'(1);

      rsp_valid   <= done || abort;
      rsp_err     <= (done || abort) && rsp_code[0];
      rsp_timeout <= (done || abort) && rsp_code[1];
      rsp_rdata   <= (done && !PWRITE && !pslverr_sel) ? prdata_sel : '0;
    end
  end

endmodule

// File: tb/tb_apb_master_nslave.sv
// Directed bench for apb_master_nslave: response scoreboard plus phase checks
// on a 2-slave/TIMEOUT=16 instance and a 4-slave/TIMEOUT=0 instance.
module tb_apb_master_nslave;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  always #5 PCLK = ~PCLK;

  logic        req_valid, req_ready, req_write;
  logic [8:0]  req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_err, rsp_timeout;
  logic [7:0]  rsp_rdata;
  logic [1:0]  PSEL;
  logic        PENABLE, PWRITE;
  logic [8:0]  PADDR;
  logic [7:0]  PWDATA;
  logic [15:0] PRDATA;
  logic [1:0]  PREADY, PSLVERR;

  logic        req_valid_4, req_ready_4, req_write_4;
  logic [8:0]  req_addr_4;
  logic [7:0]  req_wdata_4;
  logic        rsp_valid_4, rsp_err_4, rsp_timeout_4;
  logic [7:0]  rsp_rdata_4;
  logic [3:0]  PSEL_4;
  logic        PENABLE_4, PWRITE_4;
  logic [8:0]  PADDR_4;
  logic [7:0]  PWDATA_4;
  logic [31:0] PRDATA_4;
  logic [3:0]  PREADY_4, PSLVERR_4;

  apb_master_nslave #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(2), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_master_nslave #(.ADDR_W(9), .DATA_W(8), .NUM_SLV(4), .TIMEOUT(0)) dut4 (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid_4), .req_ready(req_ready_4), .req_write(req_write_4),
    .req_addr(req_addr_4), .req_wdata(req_wdata_4),
    .rsp_valid(rsp_valid_4), .rsp_rdata(rsp_rdata_4), .rsp_err(rsp_err_4),
    .rsp_timeout(rsp_timeout_4),
    .PSEL(PSEL_4), .PENABLE(PENABLE_4), .PADDR(PADDR_4), .PWRITE(PWRITE_4),
    .PWDATA(PWDATA_4), .PRDATA(PRDATA_4), .PREADY(PREADY_4), .PSLVERR(PSLVERR_4)
  );

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    logic       to;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge PCLK) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic push(input logic [7:0] rd, input logic err, input logic to, input int c);
    exp_t e;
    e.rdata = rd;
    e.err   = err;
    e.to    = to;
    e.cyc   = c;
    sb_q.push_back(e);
  endtask

  // Response monitor for the 2-slave instance.
  always @(negedge PCLK) begin
    if (rsp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", sb_q.size(), 1);
      end else begin
        mon_e = sb_q.pop_front();
        chk("rsp_cycle", cyc, mon_e.cyc);
        chk("rsp_rdata", rsp_rdata, mon_e.rdata);
        chk("rsp_err", rsp_err, mon_e.err);
        chk("rsp_timeout", rsp_timeout, mon_e.to);
      end
    end
  end

  // Single transfer on the 2-slave instance with 'waits' PREADY-low cycles.
  task automatic xfer(input logic wr, input logic [8:0] addr, input logic [7:0] wd,
                      input int waits, input logic [7:0] exp_rd, input logic exp_err,
                      input string tag);
    int         c;
    logic       sel;
    logic [1:0] exp_sel;
    c       = cyc;
    sel     = addr[8];
    exp_sel = 2'b01 << sel;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    PREADY    = 2'b11;
    if (waits > 0) PREADY[sel] = 1'b0;
    #1;
    chk({tag, "_ready_idle"}, req_ready, 1);
    push(exp_rd, exp_err, 1'b0, c + 3 + waits);
    tick();
    req_valid = 1'b0;
    chk({tag, "_setup_psel"}, PSEL, exp_sel);
    chk({tag, "_setup_penable"}, PENABLE, 0);
    chk({tag, "_setup_paddr"}, PADDR, addr);
    chk({tag, "_setup_pwrite"}, PWRITE, wr);
    chk({tag, "_setup_pwdata"}, PWDATA, wd);
    chk({tag, "_setup_ready"}, req_ready, 0);
    tick();
    for (int i = 0; i < waits; i++) begin
      chk({tag, "_wait_penable"}, PENABLE, 1);
      chk({tag, "_wait_ready"}, req_ready, 0);
      tick();
    end
    PREADY[sel] = 1'b1;
    #1;
    chk({tag, "_access_psel"}, PSEL, exp_sel);
    chk({tag, "_access_penable"}, PENABLE, 1);
    chk({tag, "_access_ready"}, req_ready, 1);
    tick();
    chk({tag, "_end_psel"}, PSEL, 0);
    chk({tag, "_end_penable"}, PENABLE, 0);
    chk({tag, "_end_paddr_hold"}, PADDR, addr);
  endtask

  initial begin
    int c;
    int seen4;
    PRESETn   = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    PRDATA    = '0;   PREADY = 2'b11;   PSLVERR = '0;
    req_valid_4 = 1'b0; req_write_4 = 1'b0; req_addr_4 = '0; req_wdata_4 = '0;
    PRDATA_4    = '0;   PREADY_4 = 4'hF;    PSLVERR_4 = '0;

    // Reset held three cycles
    tick(); tick(); tick();
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_psel4", PSEL_4, 0);
    PRESETn = 1'b1;
    tick();

    // Zero-wait write to slave 0; read data on the bus must not leak out
    PRDATA = {8'h5A, 8'hE1};
    xfer(1'b1, 9'h0A5, 8'h3C, 0, 8'h00, 1'b0, "wr0");

    // Read slave 1 with three wait states; slave 0 ready is ignored
    PRDATA = {8'h5A, 8'h99};
    xfer(1'b0, 9'h1F0, 8'h00, 3, 8'h5A, 1'b0, "rd1w3");

    // Back-to-back write then read with req_valid held high
    PREADY = 2'b11; PRDATA = {8'hC3, 8'h11};
    c = cyc;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h010; req_wdata = 8'h77;
    push(8'h00, 1'b0, 1'b0, c + 3);
    tick();
    chk("b2b_setup1_psel", PSEL, 2'b01);
    req_write = 1'b0; req_addr = 9'h110; req_wdata = 8'h00;
    push(8'hC3, 1'b0, 1'b0, c + 5);
    tick();
    chk("b2b_access1_penable", PENABLE, 1);
    chk("b2b_access1_ready", req_ready, 1);
    tick();
    chk("b2b_setup2_psel", PSEL, 2'b10);
    chk("b2b_setup2_penable", PENABLE, 0);
    chk("b2b_setup2_paddr", PADDR, 9'h110);
    chk("b2b_setup2_pwrite", PWRITE, 0);
    req_valid = 1'b0;
    tick();
    chk("b2b_access2_penable", PENABLE, 1);
    tick();
    chk("b2b_end_psel", PSEL, 0);
    tick();

    // Slave error: data suppressed, error flagged
    PRDATA = {8'hFF, 8'h42}; PSLVERR = 2'b10;
    xfer(1'b0, 9'h1F0, 8'h00, 0, 8'h00, 1'b1, "slverr1");
    // Non-selected slave errors have no effect
    PRDATA = {8'h5A, 8'h42}; PSLVERR = 2'b01;
    xfer(1'b0, 9'h1F0, 8'h00, 2, 8'h5A, 1'b0, "ign_err0");
    PSLVERR = 2'b10;
    xfer(1'b0, 9'h0F0, 8'h00, 1, 8'h42, 1'b0, "ign_err1");
    PSLVERR = 2'b00;
    tick();

    // Timeout: slave 0 never ready, slave 1 ready is ignored
    PREADY = 2'b10;
    c = cyc;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h0F0;
    push(8'h00, 1'b1, 1'b1, c + 18);
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("to_access_penable", PENABLE, 1);
      tick();
    end
    chk("to_end_psel", PSEL, 0);
    chk("to_end_penable", PENABLE, 0);
    chk("to_end_ready", req_ready, 1);
    PREADY = 2'b11;
    tick();

    // Reset during an ACCESS wait abandons the transfer silently
    PREADY = 2'b01;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h1F0; req_wdata = 8'hA5;
    tick();
    req_valid = 1'b0;
    tick(); tick();
    chk("mid_access_penable", PENABLE, 1);
    PRESETn = 1'b0;
    tick();
    chk("midrst_psel", PSEL, 0);
    chk("midrst_penable", PENABLE, 0);
    chk("midrst_paddr", PADDR, 0);
    chk("midrst_pwrite", PWRITE, 0);
    chk("midrst_pwdata", PWDATA, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    PRESETn = 1'b1; PREADY = 2'b11;
    tick(); tick();
    chk("midrst_after_rsp_valid", rsp_valid, 0);
    chk("midrst_after_ready", req_ready, 1);

    // Four slaves, timeout disabled: 100 waits then completion on slave 3
    PREADY_4 = 4'b0111; PRDATA_4 = {8'hA7, 8'h11, 8'h22, 8'h33};
    req_valid_4 = 1'b1; req_write_4 = 1'b0; req_addr_4 = 9'h180;
    tick();
    req_valid_4 = 1'b0;
    chk("n4_setup_psel", PSEL_4, 4'b1000);
    chk("n4_setup_penable", PENABLE_4, 0);
    tick();
    seen4 = 0;
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid_4 !== 1'b0) seen4++;
      tick();
    end
    chk("n4_no_abort", seen4, 0);
    chk("n4_wait_penable", PENABLE_4, 1);
    chk("n4_wait_psel", PSEL_4, 4'b1000);
    PREADY_4[3] = 1'b1;
    tick();
    chk("n4_rsp_valid", rsp_valid_4, 1);
    chk("n4_rsp_rdata", rsp_rdata_4, 8'hA7);
    chk("n4_rsp_err", rsp_err_4, 0);
    chk("n4_rsp_timeout", rsp_timeout_4, 0);
    chk("n4_end_psel", PSEL_4, 0);
    tick();
    chk("n4_rsp_pulse", rsp_valid_4, 0);

    tick(); tick();
    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
